db_event_arbiter: RTL and testbench
===================================

# db_event_arbiter

Multi-channel switch debounce controller. One shared sample-tick prescaler paces N independent debounce channels. Debounced edges are queued as per-channel pending events, and a round-robin arbiter drains them onto a single valid/ready event port. The block sits between the board switches/buttons and the control logic that consumes press/release events.

## Interface

Parameters:
- `N_CH`, 4: number of switch channels (2..16).
- `TICK_DIV`, 10: clk cycles per sample tick (≥2).
- `STABLE_TICKS`, 4: consecutive ticks a changed input must hold before `db` follows it (≥1).

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sw`, input, N_CH: raw asynchronous switch inputs.
- `db`, output, N_CH: debounced levels.
- `evt_valid`, output, 1: an event is offered.
- `evt_ready`, input, 1: the consumer accepts the event.
- `evt_ch`, output, $clog2(N_CH): channel of the offered event.
- `evt_rise`, output, 1: 1 = 0→1 edge (press), 0 = 1→0 edge (release).
- `evt_lost`, output, 1: sticky; set when an undelivered event is overwritten.

## Operation

- **Reset values.** `db`=0, `evt_valid`=0, `evt_ch`=0, `evt_rise`=0, `evt_lost`=0. The prescaler count is 0. All stability counters and pending bits are 0. The round-robin pointer `last` is N_CH-1, so channel 0 has first priority.
- **Prescaler.**
  - The count runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for exactly the one cycle in which count == TICK_DIV-1.
- **Synchronizer.** Each `sw[i]` passes through 2 flops to give `s[i]`.
- **Stability counter, per channel.** The counter is `$clog2(STABLE_TICKS+1)` bits.
  - `s[i]==db[i]`: the counter clears on any cycle.
  - `s[i]!=db[i]` and `tick`: the counter increments.
  - When it would reach STABLE_TICKS:
    - `db[i]` toggles and the counter clears.
    - `pend[i]` is set and `pdir[i]` is set to the new `db[i]` value.
- **Pending overwrite.** If `pend[i]` is already 1 when a new edge is produced, `pdir[i]` takes the newer value and `evt_lost` is set. `evt_lost` stays set until reset.
- **Arbiter FSM.**
  - ARB_IDLE:
    - If any `pend` bit is set, grant the first set channel searching last+1, last+2, … modulo N_CH.
    - Load `evt_ch`/`evt_rise`, clear that `pend` bit, set `last` = the granted channel, set `evt_valid`=1, and go to ARB_OFFER.
  - ARB_OFFER:
    - `evt_ch`/`evt_rise` stay stable while `evt_valid` is high.
    - On `evt_valid && evt_ready`: `evt_valid`=0 and go to ARB_IDLE.
  - `evt_ready` while in ARB_IDLE is ignored.
- **Simultaneous grant and new edge, same channel, same cycle.** The new edge wins: `pend[i]` stays 1 with the new direction, the offered event carries the old direction, and `evt_lost` is not set.
- **Edge on the channel currently being offered.** It sets `pend` again and is delivered later. Nothing is lost.
- **Reset mid-operation.** Everything returns immediately to the reset values, including a dropped in-flight event.

## Timing

- **`sw` to `db` latency.** 2 sync cycles, then STABLE_TICKS ticks. With the defaults this is 2 + (31..40) cycles, depending on the prescaler phase.
- **`db` to `evt_valid`.** `evt_valid` rises on the second clock edge after the edge that toggles `db`, when the arbiter is idle.
- **Throughput.** At most 1 event per 2 cycles (IDLE→OFFER→IDLE); a back-to-back accept is not supported.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- **Package `db_arb_pkg`:**
  - `arb_state_t` enum {ARB_IDLE, ARB_OFFER}.
  - Function `rr_pick(pend, last)` returning the grant index.
- **Sub-module `tick_gen`.** Parameter `DIV`; ports `clk`, `rst`, `tick`. It is the reusable prescaler.
- **Channel logic.** The synchronizer, stability counter and pending registers are a generate loop inside the top level.

## Test plan

All scenarios use N_CH=4, TICK_DIV=10, STABLE_TICKS=4 and `evt_ready` tied to 1 unless stated otherwise.

1. **Reset.** Hold `rst`=0 for 3 cycles → all outputs 0. Release, keep `sw`=0 for 200 cycles → `db`=0 and no `evt_valid`.
2. **Clean press.** Raise `sw[2]` and hold → `db[2]`=1 between 33 and 42 cycles later. One event `evt_ch`=2, `evt_rise`=1 is seen for exactly 1 cycle. Releasing gives `evt_rise`=0.
3. **Bounce rejection.** Toggle `sw[1]` every 15 cycles for 300 cycles → `db[1]` never changes and there are no events.
4. **Round robin.** Raise `sw[0]`, `sw[1]` and `sw[3]` on the same cycle, then hold `evt_ready`=0 until all three are pending. Pulse `evt_ready` → events arrive in order ch0, ch1, ch3. Then press ch0 and ch3 again → ch3 is served before ch0.
5. **Backpressure/overwrite.** With `evt_ready`=0, press then release `sw[2]` while a ch1 event is being offered → `evt_lost`=1. After ready, ch1 is delivered, then ch2 with `evt_rise`=0.
6. **Reset mid-offer.** Assert `rst`=0 while `evt_valid`=1 → `evt_valid`=0 and `db`=0 asynchronously. After release, the prescaler restarts from 0.

Source files
------------

// File: rtl/db_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : db_arb_pkg
// Purpose  : Shared types and helpers for the debounce event arbiter.
//            - arb_state_t : arbiter FSM state encoding
//            - rr_pick()   : round-robin grant search starting after 'last'
// Revision : 1.0 - initial release
// ============================================================================
package db_arb_pkg;

    // Upper bound on channel count; rr_pick works on vectors of this width.
    localparam int C_MAX_CH = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    // Returns the first set bit of pend visiting last+1, last+2, ... mod n_ch.
    // If nothing is set the previous pointer is returned unchanged.
    function automatic logic [3:0] rr_pick(
        input logic [C_MAX_CH-1:0] pend,
        input logic [3:0]          last,
        input int                  n_ch
    );
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= C_MAX_CH; k++) begin
            idx = (int'(last) + k) % n_ch;
            if (!found && (k <= n_ch) && pend[4'(idx)]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running prescaler; count runs 0..DIV-1 and wraps.
//            tick is high for the single cycle in which count == DIV-1.
// Ports    : clk  - clock
//            rst  - asynchronous active-low reset (count -> 0)
//            tick - one-cycle strobe every DIV clocks
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/db_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : db_event_arbiter
// Purpose  : N-channel switch debouncer with round-robin event delivery.
//            Each channel: 2-flop synchronizer, tick-paced stability counter,
//            pending-event register. A 2-state arbiter drains pending events
//            onto one valid/ready port.
// Ports    : clk, rst (async active-low)
//            sw        - raw switch inputs
//            db        - debounced levels
//            evt_valid / evt_ready - event handshake
//            evt_ch    - channel of offered event
//            evt_rise  - 1 = press (0->1), 0 = release (1->0)
//            evt_lost  - sticky, an undelivered event was overwritten
// Revision : 1.0 - initial release
// ============================================================================
module db_event_arbiter
    import db_arb_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 10,
    parameter int STABLE_TICKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw,
    output logic [N_CH-1:0]         db,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic                    evt_rise,
    output logic                    evt_lost
);

    localparam int                C_CH_W    = $clog2(N_CH);
    localparam int                C_ST_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [C_ST_W-1:0] C_ST_LAST = C_ST_W'(STABLE_TICKS - 1);

    logic              w_tick;
    logic [N_CH-1:0]   w_pend;
    logic [N_CH-1:0]   w_pdir;
    logic [N_CH-1:0]   w_lost;
    logic [N_CH-1:0]   w_clr;
    logic [C_CH_W-1:0] w_grant;
    logic [C_MAX_CH-1:0] w_pend16;
    logic [3:0]        w_last4;

    arb_state_t        r_state;
    logic [C_CH_W-1:0] r_last;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              r_meta;
        logic              r_sync;
        logic [C_ST_W-1:0] r_stab;
        logic              r_db;
        logic              r_db_q;
        logic              r_pend;
        logic              r_pdir;
        logic              w_edge;

        // Edge is taken from the registered db so the event enters the
        // pending register one cycle after db toggles.
        assign w_edge = r_db ^ r_db_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_stab <= '0;
                r_db   <= 1'b0;
                r_db_q <= 1'b0;
                r_pend <= 1'b0;
                r_pdir <= 1'b0;
            end else begin
                r_meta <= sw[i];
                r_sync <= r_meta;
                r_db_q <= r_db;

                if (r_sync == r_db) begin
                    r_stab <= '0;
                end else if (w_tick) begin
                    if (r_stab == C_ST_LAST) begin
                        r_db   <= ~r_db;
                        r_stab <= '0;
                    end else begin
                        r_stab <= r_stab + 1'b1;
                    end
                end

                // A new edge beats a same-cycle grant: the arbiter takes the
                // old direction, the new one stays pending.
                if (w_edge) begin
                    r_pend <= 1'b1;
                    r_pdir <= r_db;
                end else if (w_clr[i]) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign db[i]     = r_db;
        assign w_pend[i] = r_pend;
        assign w_pdir[i] = r_pdir;
        // Overwrite counts as lost only if the old event is not leaving now.
        assign w_lost[i] = w_edge & r_pend & ~w_clr[i];
    end

    always_comb begin
        w_pend16             = '0;
        w_pend16[N_CH-1:0]   = w_pend;
        w_last4              = '0;
        w_last4[C_CH_W-1:0]  = r_last;
        w_grant              = C_CH_W'(rr_pick(w_pend16, w_last4, N_CH));
        w_clr                = '0;
        if ((r_state == ARB_IDLE) && (|w_pend)) begin
            w_clr[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ARB_IDLE;
            r_last    <= C_CH_W'(N_CH - 1);
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            evt_lost  <= 1'b0;
        end else begin
            evt_lost <= evt_lost | (|w_lost);
            case (r_state)
                ARB_IDLE: begin
                    if (|w_pend) begin
                        evt_ch    <= w_grant;
                        evt_rise  <= w_pdir[w_grant];
                        r_last    <= w_grant;
                        evt_valid <= 1'b1;
                        r_state   <= ARB_OFFER;
                    end
                end
                ARB_OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        r_state   <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_db_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_db_event_arbiter
// Purpose  : Directed self-checking bench for db_event_arbiter
//            (N_CH=4, TICK_DIV=10, STABLE_TICKS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_db_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] db;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic       evt_lost;

    int total = 0;
    int bad   = 0;

    // Accepted events as {ch, rise}
    logic [2:0] evq[$];

    db_event_arbiter #(
        .N_CH         (4),
        .TICK_DIV     (10),
        .STABLE_TICKS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .db        (db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .evt_lost  (evt_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && evt_valid && evt_ready) evq.push_back({evt_ch, evt_rise});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int vcnt;
        rst = 1'b0; sw = 4'b0000; evt_ready = 1'b1;
        step(3);
        total++; if (db !== 4'b0000) begin bad++; $display("FAIL reset_db: got %b want 0000", db); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if (evt_ch !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", evt_ch); end
        total++; if (evt_rise !== 1'b0) begin bad++; $display("FAIL reset_rise: got %b want 0", evt_rise); end
        total++; if (evt_lost !== 1'b0) begin bad++; $display("FAIL reset_lost: got %b want 0", evt_lost); end
        rst = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if (evt_valid) vcnt++;
        end
        total++; if (db !== 4'b0000) begin bad++; $display("FAIL idle_db: got %b want 0000", db); end
        total++; if (vcnt != 0) begin bad++; $display("FAIL idle_events: got %0d want 0", vcnt); end
    endtask

    task automatic test_clean_press();
        int first_db, first_v, vcnt;
        evq.delete();
        first_db = -1; first_v = -1; vcnt = 0;
        sw[2] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step(1);
            if (db[2] && first_db < 0) first_db = c;
            if (evt_valid) begin
                vcnt++;
                if (first_v < 0) first_v = c;
                total++; if (evt_ch !== 2'd2 || evt_rise !== 1'b1) begin
                    bad++; $display("FAIL press_evt: got ch=%0d rise=%b want ch=2 rise=1", evt_ch, evt_rise);
                end
            end
        end
        total++; if (first_db < 33 || first_db > 42) begin bad++; $display("FAIL press_latency: got %0d want 33..42", first_db); end
        total++; if (first_v != first_db + 2) begin bad++; $display("FAIL db_to_valid: got %0d want %0d", first_v, first_db + 2); end
        total++; if (vcnt != 1) begin bad++; $display("FAIL press_valid_cycles: got %0d want 1", vcnt); end
        evq.delete();
        sw[2] = 1'b0;
        step(60);
        total++; if (db !== 4'b0000) begin bad++; $display("FAIL release_db: got %b want 0000", db); end
        total++; if (evq.size() != 1) begin bad++; $display("FAIL release_count: got %0d want 1", evq.size()); end
        else begin
            total++; if (evq[0] !== {2'd2, 1'b0}) begin bad++; $display("FAIL release_evt: got %b want 100", evq[0]); end
        end
    endtask

    task automatic test_bounce();
        int db_moved;
        evq.delete();
        db_moved = 0;
        for (int c = 0; c < 300; c++) begin
            if (c % 15 == 0) sw[1] = ~sw[1];
            step(1);
            if (db[1]) db_moved++;
        end
        step(60);
        total++; if (db_moved != 0) begin bad++; $display("FAIL bounce_db: got %0d high cycles want 0", db_moved); end
        total++; if (evq.size() != 0) begin bad++; $display("FAIL bounce_events: got %0d want 0", evq.size()); end
    endtask

    task automatic test_round_robin();
        // Fresh reset so the pointer starts at N_CH-1 (channel 0 first).
        rst = 1'b0; sw = 4'b0000; evt_ready = 1'b0;
        step(2);
        rst = 1'b1;
        evq.delete();
        sw = 4'b1011;
        step(60);
        total++; if (db !== 4'b1011) begin bad++; $display("FAIL rr_db: got %b want 1011", db); end
        total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_rise !== 1'b1) begin
            bad++; $display("FAIL rr_stall: got v=%b ch=%0d rise=%b want v=1 ch=0 rise=1", evt_valid, evt_ch, evt_rise);
        end
        evt_ready = 1'b1;
        step(10);
        total++; if (evq.size() != 3) begin bad++; $display("FAIL rr_count: got %0d want 3", evq.size()); end
        else begin
            total++; if (evq[0] !== 3'b001 || evq[1] !== 3'b011 || evq[2] !== 3'b111) begin
                bad++; $display("FAIL rr_order: got %b %b %b want 001 011 111", evq[0], evq[1], evq[2]);
            end
        end
        // Release 0 and 3 (pointer ends at 3), then 1 (pointer at 1).
        sw[0] = 1'b0; sw[3] = 1'b0;
        step(60);
        sw[1] = 1'b0;
        step(60);
        evq.delete();
        sw[0] = 1'b1; sw[3] = 1'b1;
        step(60);
        total++; if (evq.size() != 2) begin bad++; $display("FAIL rr2_count: got %0d want 2", evq.size()); end
        else begin
            total++; if (evq[0] !== 3'b111 || evq[1] !== 3'b001) begin
                bad++; $display("FAIL rr2_order: got %b %b want 111 001", evq[0], evq[1]);
            end
        end
    endtask

    task automatic test_overwrite();
        evt_ready = 1'b0;
        sw[1] = 1'b1;
        step(50);
        total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_rise !== 1'b1) begin
            bad++; $display("FAIL ow_offer: got v=%b ch=%0d rise=%b want v=1 ch=1 rise=1", evt_valid, evt_ch, evt_rise);
        end
        sw[2] = 1'b1;
        step(50);
        total++; if (evt_lost !== 1'b0) begin bad++; $display("FAIL ow_lost_early: got %b want 0", evt_lost); end
        sw[2] = 1'b0;
        step(50);
        total++; if (evt_lost !== 1'b1) begin bad++; $display("FAIL ow_lost: got %b want 1", evt_lost); end
        total++; if (evt_ch !== 2'd1) begin bad++; $display("FAIL ow_ch_stable: got %0d want 1", evt_ch); end
        evq.delete();
        evt_ready = 1'b1;
        step(10);
        total++; if (evq.size() != 2) begin bad++; $display("FAIL ow_count: got %0d want 2", evq.size()); end
        else begin
            total++; if (evq[0] !== 3'b011 || evq[1] !== 3'b100) begin
                bad++; $display("FAIL ow_order: got %b %b want 011 100", evq[0], evq[1]);
            end
        end
        total++; if (evt_lost !== 1'b1 || db !== 4'b1011) begin
            bad++; $display("FAIL ow_final: got lost=%b db=%b want lost=1 db=1011", evt_lost, db);
        end
    endtask

    task automatic test_reset_mid_offer();
        evt_ready = 1'b0;
        sw[1] = 1'b0;
        step(50);
        total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_rise !== 1'b0) begin
            bad++; $display("FAIL mid_offer: got v=%b ch=%0d rise=%b want v=1 ch=1 rise=0", evt_valid, evt_ch, evt_rise);
        end
        rst = 1'b0;
        #1;
        total++; if (evt_valid !== 1'b0 || db !== 4'b0000 || evt_lost !== 1'b0) begin
            bad++; $display("FAIL async_reset: got v=%b db=%b lost=%b want 0 0000 0", evt_valid, db, evt_lost);
        end
        sw = 4'b0001;
        step(3);
        rst = 1'b1;
        evt_ready = 1'b1;
        // Prescaler restarts at 0: ticks at edges 10,20,30,40 -> db at edge 40,
        // event offered at edge 42.
        for (int k = 1; k <= 42; k++) begin
            step(1);
            if (k == 39) begin
                total++; if (db !== 4'b0000) begin bad++; $display("FAIL restart_db39: got %b want 0000", db); end
            end
            if (k == 40) begin
                total++; if (db !== 4'b0001) begin bad++; $display("FAIL restart_db40: got %b want 0001", db); end
            end
            if (k == 41) begin
                total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL restart_v41: got %b want 0", evt_valid); end
            end
            if (k == 42) begin
                total++; if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_rise !== 1'b1) begin
                    bad++; $display("FAIL restart_evt: got v=%b ch=%0d rise=%b want v=1 ch=0 rise=1", evt_valid, evt_ch, evt_rise);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; sw = 4'b0000; evt_ready = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_round_robin();
        test_overwrite();
        test_reset_mid_offer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
